// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_pkg
// Description : Shared widths, defaults, operation encoding and parameter
//               helper functions for the fetch queue slice.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

    // Pipeline width defaults shared by fetch, the queue and decode
    localparam int FQ_IWIDTH_DEFAULT   = 32;
    localparam int FQ_PC_WIDTH_DEFAULT = 32;
    localparam int FQ_DEPTH_DEFAULT    = 4;

    // Per-cycle queue operation, {push, pop}
    typedef enum logic [1:0] {
        FQ_OP_HOLD = 2'b00,
        FQ_OP_POP  = 2'b01,
        FQ_OP_PUSH = 2'b10,
        FQ_OP_BOTH = 2'b11
    } fq_op_e;

    // Depth must be a power of two so the pointers wrap for free
    function automatic bit fq_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // Occupancy needs one bit more than the pointers to represent "full"
    function automatic int fq_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_mem
// Description : Entry storage for the fetch queue. One synchronous write
//               port and one asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH_DEFAULT,
    parameter int DWIDTH = FQ_IWIDTH_DEFAULT + FQ_PC_WIDTH_DEFAULT,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    // Write port: capture the entry on an accepted push
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port is combinational so the head falls through immediately
    assign o_rdata = r_mem[i_raddr];

endmodule : fetch_queue_mem
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : First-word-fall-through instruction queue between fetch and
//               decode. Throttles fetch at an almost-full level, supports a
//               flush that discards everything, and an optional pass-through
//               path that hands an instruction straight to decode when the
//               queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int IWIDTH    = FQ_IWIDTH_DEFAULT,
    parameter int PC_WIDTH  = FQ_PC_WIDTH_DEFAULT,
    parameter int DEPTH     = FQ_DEPTH_DEFAULT,
    parameter int AFULL_LVL = DEPTH - 1,
    parameter bit BYPASS    = 1'b0
) (
    input  logic                           fq_clk,
    input  logic                           fq_rst,
    input  logic                           fq_i_ce,
    input  logic [IWIDTH-1:0]              fq_i_instr,
    input  logic [PC_WIDTH-1:0]            fq_i_pc,
    output logic                           fq_o_stall,
    input  logic                           fq_i_stall,
    input  logic                           fq_i_flush,
    output logic                           fq_o_ce,
    output logic [IWIDTH-1:0]              fq_o_instr,
    output logic [PC_WIDTH-1:0]            fq_o_pc,
    output logic [fq_cnt_width(DEPTH)-1:0] fq_o_count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = fq_cnt_width(DEPTH);
    localparam int c_dw = PC_WIDTH + IWIDTH;

    localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_afull   = c_cw'(AFULL_LVL);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

    // Reject illegal configurations at elaboration time
    generate
        if (!fq_depth_ok(DEPTH) || (AFULL_LVL < 1) || (AFULL_LVL > DEPTH)) begin : g_bad_params
            $error("fetch_queue: DEPTH must be a power of two >= 2 and AFULL_LVL within 1..DEPTH");
        end
    endgenerate

    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;

    logic            w_q_valid;   // at least one stored entry
    logic            w_bypass;    // empty queue presenting fetch input directly
    logic            w_byp_take;  // pass-through instruction consumed by decode
    logic            w_pop;       // stored head consumed by decode
    logic            w_push;      // fetch input written into storage
    logic [c_dw-1:0] w_rdata;
    fq_op_e          w_op;

    assign w_q_valid = (r_count != '0);

    // The pass-through path only exists when it is configured in
    generate
        if (BYPASS) begin : g_bypass
            assign w_bypass = fq_i_ce && !w_q_valid;
        end else begin : g_no_bypass
            assign w_bypass = 1'b0;
        end
    endgenerate

    // Flush outranks everything: no pop, no pass-through, no push
    assign w_pop      = w_q_valid && !fq_i_stall && !fq_i_flush;
    assign w_byp_take = w_bypass && !fq_i_stall && !fq_i_flush;

    // A full queue still accepts when the head leaves in the same cycle.
    // A pass-through instruction that decode takes is never stored; one
    // that decode stalls on is written so it stays at the head.
    assign w_push = fq_i_ce && !fq_i_flush && !w_byp_take
                 && ((r_count != c_depth) || w_pop);

    assign w_op = fq_op_e'({w_push, w_pop});

    fetch_queue_mem #(
        .DEPTH  (DEPTH),
        .DWIDTH (c_dw),
        .AWIDTH (c_aw)
    ) u_mem (
        .clk     (fq_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({fq_i_pc, fq_i_instr}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Pointer and occupancy update; reset and flush both empty the queue
    always_ff @(posedge fq_clk) begin
        if (!fq_rst || fq_i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            unique case (w_op)
                FQ_OP_PUSH: r_count <= r_count + c_cnt_one;
                FQ_OP_POP:  r_count <= r_count - c_cnt_one;
                default:    r_count <= r_count;
            endcase
        end
    end

    // Decode-side outputs: stored head first, then pass-through, else zeros
    always_comb begin
        fq_o_ce    = 1'b0;
        fq_o_instr = '0;
        fq_o_pc    = '0;
        if (!fq_i_flush) begin
            if (w_q_valid) begin
                fq_o_ce               = 1'b1;
                {fq_o_pc, fq_o_instr} = w_rdata;
            end else if (w_bypass) begin
                fq_o_ce    = 1'b1;
                fq_o_instr = fq_i_instr;
                fq_o_pc    = fq_i_pc;
            end
        end
    end

    // Fetch is held off near full and while the pipe is being flushed
    assign fq_o_stall = (r_count >= c_afull) || fq_i_flush;
    assign fq_o_count = r_count;

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Scoreboard bench for fetch_queue. Two instances share one
//               stimulus stream: index 0 without pass-through, index 1 with.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic fq_clk = 1'b0;
    always #5 fq_clk = ~fq_clk;

    logic        fq_rst;
    logic        fq_i_ce;
    logic [31:0] fq_i_instr;
    logic [31:0] fq_i_pc;
    logic        fq_i_stall;
    logic        fq_i_flush;

    logic [1:0]       o_ce;
    logic [1:0]       o_stall;
    logic [1:0][31:0] o_instr;
    logic [1:0][31:0] o_pc;
    logic [1:0][2:0]  o_cnt;

    fetch_queue #(.IWIDTH(32), .PC_WIDTH(32), .DEPTH(4), .AFULL_LVL(3), .BYPASS(1'b0)) u_dut (
        .fq_clk(fq_clk), .fq_rst(fq_rst), .fq_i_ce(fq_i_ce), .fq_i_instr(fq_i_instr),
        .fq_i_pc(fq_i_pc), .fq_o_stall(o_stall[0]), .fq_i_stall(fq_i_stall),
        .fq_i_flush(fq_i_flush), .fq_o_ce(o_ce[0]), .fq_o_instr(o_instr[0]),
        .fq_o_pc(o_pc[0]), .fq_o_count(o_cnt[0])
    );

    fetch_queue #(.IWIDTH(32), .PC_WIDTH(32), .DEPTH(4), .AFULL_LVL(3), .BYPASS(1'b1)) u_dut_byp (
        .fq_clk(fq_clk), .fq_rst(fq_rst), .fq_i_ce(fq_i_ce), .fq_i_instr(fq_i_instr),
        .fq_i_pc(fq_i_pc), .fq_o_stall(o_stall[1]), .fq_i_stall(fq_i_stall),
        .fq_i_flush(fq_i_flush), .fq_o_ce(o_ce[1]), .fq_o_instr(o_instr[1]),
        .fq_o_pc(o_pc[1]), .fq_o_count(o_cnt[1])
    );

    // Reference model state (driver side): occupancy per instance
    int              occ [2];
    logic [1:0]      push_pend;
    logic [1:0]      pop_pend;
    logic            clr_pend;
    // Handed from driver to monitor each cycle
    logic            sb_clr_now;
    logic [1:0]      iss_valid;
    logic [1:0][63:0] iss_item;
    logic [1:0]      exp_ce;
    logic [1:0]      exp_stall;
    logic [1:0][2:0] exp_cnt;
    logic            chk_en;
    logic            end_chk;

    // Expected delivery order, {pc, instr}, one queue per instance
    logic [63:0] sb0 [$];
    logic [63:0] sb1 [$];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic int sb_len(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic logic [63:0] sb_front(input int d);
        return (d == 0) ? sb0[0] : sb1[0];
    endfunction

    task automatic sb_push(input int d, input logic [63:0] v);
        if (d == 0) sb0.push_back(v);
        else        sb1.push_back(v);
    endtask

    task automatic sb_pop(input int d);
        if (d == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
    endtask

    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%h, expected 0x%h", name, d, act, exp);
        end
    endtask

    // Monitor: applies edge clears and issued entries, then compares outputs
    always @(negedge fq_clk) begin
        if (sb_clr_now) begin
            sb0.delete();
            sb1.delete();
        end
        for (int d = 0; d < 2; d++) begin
            if (iss_valid[d]) sb_push(d, iss_item[d]);
            if (chk_en) begin
                check("count",   d, 64'(o_cnt[d]),   64'(exp_cnt[d]));
                check("o_stall", d, 64'(o_stall[d]), 64'(exp_stall[d]));
                check("o_ce",    d, 64'(o_ce[d]),    64'(exp_ce[d]));
                if (o_ce[d] === 1'b1) begin
                    if (sb_len(d) == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output dut%0d: got pc=0x%h, expected no valid output", d, o_pc[d]);
                    end else begin
                        check("head", d, {o_pc[d], o_instr[d]}, sb_front(d));
                        if (!fq_i_stall) sb_pop(d);
                    end
                end else begin
                    check("idle_zero", d, {o_pc[d], o_instr[d]}, 64'd0);
                end
                if (end_chk) check("undelivered", d, 64'(sb_len(d)), 64'd0);
            end
        end
    end

    // One clock of stimulus; also advances the occupancy model across the edge
    task automatic cyc(input logic ce, input logic [31:0] pc, input logic stall,
                       input logic flush, input logic rst_n);
        logic popq;
        logic take;
        logic push;
        logic [31:0] instr;
        @(posedge fq_clk);
        #1;
        sb_clr_now = clr_pend;
        for (int d = 0; d < 2; d++) begin
            if (clr_pend) occ[d] = 0;
            else          occ[d] = occ[d] + (push_pend[d] ? 1 : 0) - (pop_pend[d] ? 1 : 0);
        end
        instr      = $urandom;
        fq_i_ce    = ce;
        fq_i_pc    = pc;
        fq_i_instr = instr;
        fq_i_stall = stall;
        fq_i_flush = flush;
        fq_rst     = rst_n;
        for (int d = 0; d < 2; d++) begin
            exp_ce[d]    = !flush && ((occ[d] > 0) || ((d == 1) && ce));
            exp_stall[d] = (occ[d] >= 3) || flush;
            exp_cnt[d]   = 3'(occ[d]);
            popq = (occ[d] > 0) && !stall && !flush;
            take = (d == 1) && (occ[d] == 0) && ce && !stall && !flush;
            push = ce && !flush && !take && ((occ[d] < 4) || popq);
            push_pend[d] = push;
            pop_pend[d]  = popq;
            iss_valid[d] = push || take;
            iss_item[d]  = {pc, instr};
        end
        clr_pend = !rst_n || flush;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic stall);
        cyc(1'b1, pc, stall, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        fq_rst = 1'b0; fq_i_ce = 1'b0; fq_i_pc = '0; fq_i_instr = '0;
        fq_i_stall = 1'b0; fq_i_flush = 1'b0;
        occ[0] = 0; occ[1] = 0;
        push_pend = '0; pop_pend = '0; clr_pend = 1'b1;
        sb_clr_now = 1'b0; iss_valid = '0; iss_item = '0;
        exp_ce = '0; exp_stall = '0; exp_cnt = '0;
        chk_en = 1'b0; end_chk = 1'b0;

        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        idle(1);

        // Fill to the throttle level while decode is stalled, head held at PC 0
        push_one(32'd0, 1'b1);
        push_one(32'd4, 1'b1);
        push_one(32'd8, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        // Fill to full, then a push without a pop is dropped
        push_one(32'd12, 1'b1);
        push_one(32'd16, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        idle(6);

        // Full queue: push with a simultaneous pop keeps count at DEPTH
        push_one(32'd0, 1'b1);
        push_one(32'd4, 1'b1);
        push_one(32'd8, 1'b1);
        push_one(32'd12, 1'b1);
        push_one(32'd16, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        idle(6);

        // Flush at count 2 with a same-cycle push
        push_one(32'd0, 1'b1);
        push_one(32'd4, 1'b1);
        cyc(1'b1, 32'h0000_099c, 1'b0, 1'b1, 1'b1);
        idle(3);

        // Empty queue, unstalled push: pass-through on the bypass instance
        push_one(32'd20, 1'b0);
        idle(3);
        // Empty queue, stalled push: pass-through shown and retained
        push_one(32'd24, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Continuous streaming across two pointer wraps, then reset mid-stream
        for (int k = 0; k < 10; k++) push_one(32'(k * 4), 1'b0);
        cyc(1'b1, 32'd40, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 9) < 7,
                $urandom & 32'hffff_fffc,
                $urandom_range(0, 9) < 3,
                $urandom_range(0, 99) < 3,
                !($urandom_range(0, 199) < 1));
        end

        idle(8);
        end_chk = 1'b1;
        @(negedge fq_clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
